// File: rtl/quad_encoder_gen_if.sv
// Command channel of the quadrature encoder generator: one command
// (direction, edge count, edge spacing) handed over per valid/ready beat.
interface quad_encoder_gen_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic             cmd_abort;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator: emits N A/B edges at a programmable
// spacing and direction while tracking its own signed position.
module quad_encoder_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  quad_encoder_gen_if.slave  cmd,
  output logic [1:0]         enc_out,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   steps_left,
  output logic [31:0]        position
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic [1:0]       enc_d, phase_nxt;
  logic [31:0]      pos_d;
  logic [CNT_W-1:0] steps_d;
  logic             done_d, aborted_d;

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q == RUN);

  // {B,A}: forward rotates to {A,~B}, reverse to {~A,B}; one bit flips per edge.
  assign phase_nxt = dir_q ? {enc_out[0], ~enc_out[1]}
                           : {~enc_out[0], enc_out[1]};

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    period_d  = period_q;
    dir_d     = dir_q;
    enc_d     = enc_out;
    pos_d     = position;
    steps_d   = steps_left;
    done_d    = 1'b0;
    aborted_d = aborted;
    unique case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          aborted_d = 1'b0;
          steps_d   = cmd.cmd_steps;
          if (cmd.cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            dir_d    = cmd.cmd_dir;
            period_d = (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;
            timer_d  = period_d;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        // Abort wins over a step falling due on the same edge.
        if (cmd.cmd_abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (timer_q == DIV_W'(1)) begin
          enc_d   = phase_nxt;
          pos_d   = dir_q ? position + 32'd1 : position - 32'd1;
          steps_d = steps_left - CNT_W'(1);
          timer_d = period_q;
          if (steps_left == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      period_q   <= '0;
      dir_q      <= 1'b0;
      enc_out    <= '0;
      position   <= '0;
      steps_left <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      period_q   <= period_d;
      dir_q      <= dir_d;
      enc_out    <= enc_d;
      position   <= pos_d;
      steps_left <= steps_d;
      done       <= done_d;
      aborted    <= aborted_d;
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Scoreboard bench for quad_encoder_gen: a reference model pushes per-cycle
// expectations at command issue; a negedge monitor pops and compares them.
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  enc_out;
  logic        busy, done, aborted;
  logic [15:0] steps_left;
  logic [31:0] position;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    int unsigned at;
    logic [1:0]  enc;
    logic [31:0] pos;
    logic [15:0] sl;
    logic        busy;
    logic        done;
    logic        ab;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [1:0]  m_phase = 2'b00;
  logic [31:0] m_pos = 32'd0;
  logic        m_ab = 1'b0;
  logic        prev_done = 1'b0;

  quad_encoder_gen_if #(.CNT_W(16), .DIV_W(16)) bus ();

  quad_encoder_gen #(.CNT_W(16), .DIV_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (bus),
    .enc_out    (enc_out),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_left (steps_left),
    .position   (position)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic fwd);
    logic [1:0] seq [4];
    int unsigned idx;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    idx = 0;
    for (int unsigned i = 0; i < 4; i++) if (seq[i] == ph) idx = i;
    return fwd ? seq[(idx + 1) % 4] : seq[(idx + 3) % 4];
  endfunction

  task automatic push(input int unsigned at, input logic [15:0] sl, input logic b,
                      input logic d, input logic r);
    exp_t e;
    e.at = at; e.enc = m_phase; e.pos = m_pos; e.sl = sl;
    e.busy = b; e.done = d; e.ab = m_ab; e.rdy = r;
    exp_q.push_back(e);
  endtask

  // Builds the expected trace of one command accepted at edge k.
  task automatic model_cmd(input logic dir, input int unsigned n, input int unsigned p,
                           input int unsigned k, input int unsigned abort_step);
    int unsigned pe, last, t;
    pe = (p == 0) ? 1 : p;
    m_ab = 1'b0;
    if (n == 0) begin
      push(k, 16'd0, 1'b0, 1'b1, 1'b1);
      push(k + 1, 16'd0, 1'b0, 1'b0, 1'b1);
      return;
    end
    push(k, 16'(n), 1'b1, 1'b0, 1'b0);
    last = (abort_step != 0) ? abort_step - 1 : n;
    for (int unsigned s = 1; s <= last; s++) begin
      m_phase = phase_step(m_phase, dir);
      m_pos   = dir ? m_pos + 32'd1 : m_pos - 32'd1;
      t = k + s * pe;
      if (abort_step == 0 && s == n) begin
        push(t, 16'(n - s), 1'b0, 1'b1, 1'b1);
        push(t + 1, 16'(n - s), 1'b0, 1'b0, 1'b1);
      end else begin
        push(t, 16'(n - s), 1'b1, 1'b0, 1'b0);
      end
    end
    if (abort_step != 0) begin
      t = k + abort_step * pe;
      m_ab = 1'b1;
      push(t, 16'(n - last), 1'b0, 1'b1, 1'b1);
      push(t + 1, 16'(n - last), 1'b0, 1'b0, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (done) chk("done_twice", {31'd0, prev_done}, 32'd0);
    prev_done = done;
    if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
      while (exp_q.size() != 0 && exp_q[0].at == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("enc_out",    {30'd0, enc_out}, {30'd0, e.enc});
        chk("position",   position, e.pos);
        chk("steps_left", {16'd0, steps_left}, {16'd0, e.sl});
        chk("busy",       {31'd0, busy}, {31'd0, e.busy});
        chk("done",       {31'd0, done}, {31'd0, e.done});
        chk("aborted",    {31'd0, aborted}, {31'd0, e.ab});
        chk("cmd_ready",  {31'd0, bus.cmd_ready}, {31'd0, e.rdy});
      end
    end else begin
      chk("done_spurious", {31'd0, done}, 32'd0);
    end
  end

  task automatic wait_cyc(input int unsigned target);
    int unsigned w = 0;
    while (cyc < target && w < 10000) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic send(input logic dir, input int unsigned n, input int unsigned p,
                      input logic ab, input int unsigned abort_step,
                      output int unsigned k);
    int unsigned w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (bus.cmd_ready !== 1'b1) chk("ready_timeout", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_dir    = dir;
    bus.cmd_steps  = 16'(n);
    bus.cmd_period = 16'(p);
    bus.cmd_abort  = ab;
    k = cyc + 1;
    model_cmd(dir, n, p, k, abort_step);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_abort = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_enc"},   {30'd0, enc_out}, 32'd0);
    chk({tag, "_pos"},   position, 32'd0);
    chk({tag, "_sl"},    {16'd0, steps_left}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_rdy"},   {31'd0, bus.cmd_ready}, 32'd1);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_abort"}, {31'd0, aborted}, 32'd0);
  endtask

  initial begin
    int unsigned k;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_steps = '0;
    bus.cmd_period = '0;  bus.cmd_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    // Forward 4 edges, period 3
    send(1'b1, 4, 3, 1'b0, 0, k);
    drain();
    // Reverse 3 edges, period 0 acts as 1
    send(1'b0, 3, 0, 1'b0, 0, k);
    drain();
    // Zero-step command
    send(1'b1, 0, 7, 1'b0, 0, k);
    drain();

    // Abort on the edge where step 3 is due; a stray command in RUN is ignored
    send(1'b1, 10, 5, 1'b0, 3, k);
    wait_cyc(k + 2);
    bus.cmd_valid = 1'b1; bus.cmd_steps = 16'd7; bus.cmd_period = 16'd1; bus.cmd_dir = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_cyc(k + 14);
    bus.cmd_abort = 1'b1;
    @(negedge clk);
    bus.cmd_abort = 1'b0;
    drain();

    // Abort in IDLE ignored; abort together with acceptance ignored
    bus.cmd_abort = 1'b1;
    repeat (2) @(negedge clk);
    send(1'b0, 2, 2, 1'b1, 0, k);
    drain();

    // Wrap 0x7FFFFFFF -> 0x80000000
    force dut.position = 32'h7FFF_FFFF;
    #1;
    release dut.position;
    m_pos = 32'h7FFF_FFFF;
    @(negedge clk);
    send(1'b1, 1, 1, 1'b0, 0, k);
    drain();

    // Asynchronous reset between edges of a running command
    send(1'b1, 4, 3, 1'b0, 0, k);
    wait_cyc(k + 4);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_state("midrun");
    m_phase = 2'b00; m_pos = 32'd0; m_ab = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(1'b1, 4, 3, 1'b0, 0, k);
    drain();

    // Wrap 0 -> 0xFFFFFFFF after a clean reset
    reset = 1'b1;
    m_phase = 2'b00; m_pos = 32'd0; m_ab = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(1'b0, 1, 2, 1'b0, 0, k);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/quad_encoder_gen.md
# quad_encoder_gen

Quadrature encoder signal generator: the transmitting end of the 2-bit encoder interface consumed by the Nios system's encoder input. On a command it emits N quadrature edges on A/B at a programmable edge spacing and direction, and tracks its own signed position. Used in the lab fixture and simulation to stand in for the motor encoder and drive the on-chip decoder.

## Interface
- CNT_W, 16: width of step count (cmd_steps, steps_left)
- DIV_W, 16: width of edge period (cmd_period), in clk cycles
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cmd_valid  in  1  command present
- cmd_ready  out  1  generator idle, command accepted on cmd_valid & cmd_ready at rising edge
- cmd_dir  in  1  1 = forward (A leads B), 0 = reverse
- cmd_steps  in  CNT_W  number of quadrature edges to emit
- cmd_period  in  DIV_W  clk cycles between edges; 0 treated as 1
- cmd_abort  in  1  stop current command at next edge
- enc_out  out  2  bit0 = A, bit1 = B; registered
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion or abort
- aborted  out  1  qualifies done: 1 if completion was by abort; held until next acceptance
- steps_left  out  CNT_W  edges still to emit
- position  out  32  signed edge count, two's complement

## Operation
- States: IDLE, RUN. cmd_ready = 1 in IDLE, 0 in RUN; busy = inverse.
- Phase sequence {B,A}: forward 00→01→11→10→00; reverse 00→10→11→01→00. Exactly one bit changes per edge; phase persists across commands (never reset by a new command).
- IDLE, accept with cmd_steps = 0: stay IDLE, done = 1 next cycle, aborted = 0, no edge.
- IDLE, accept with cmd_steps = N > 0: latch dir, P = max(cmd_period,1); steps_left = N; timer = P; aborted cleared; go RUN.
- RUN each cycle: timer decrements; when timer reaches 1 on a clock edge: advance phase, position ±1, steps_left −1, timer reloads P. If that was the last step: go IDLE, done = 1.
- cmd_abort in RUN: go IDLE at that edge, done = 1, aborted = 1; any step due at the same edge is suppressed; steps_left holds remaining count.
- cmd_abort in IDLE ignored; cmd_abort with a command acceptance in IDLE: command accepted, abort ignored.
- cmd_valid in RUN ignored (not queued); inputs other than cmd_abort sampled only at acceptance.
- position: +1 per forward edge, −1 per reverse edge, wraps modulo 2^32 (0x7FFFFFFF+1 → 0x80000000, 0 −1 → 0xFFFFFFFF).

## Timing
- Reset values: enc_out = 00, position = 0, steps_left = 0, busy = 0, cmd_ready = 1, done = 0, aborted = 0, state IDLE, timer = 0.
- Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronous); no done pulse.
- Acceptance at edge k: busy = 1 after edge k. Edge n (1..N) of enc_out changes at edge k + n·P.
- Last edge at k + N·P: busy = 0, cmd_ready = 1, done = 1 in the same cycle; done = 0 next cycle. Earliest re-acceptance at k + N·P + 1.
- Zero-step command: done high for cycle after edge k; cmd_ready never drops.
- done is never asserted for two consecutive cycles.

## Test plan
- Forward: phase 00, cmd_steps = 4, cmd_period = 3 accepted at edge k → enc_out 01,11,10,00 at k+3,k+6,k+9,k+12; position = 4; done pulse at k+12.
- Reverse with period 0: phase 00, steps = 3, period = 0 → enc_out 10,11,01 on consecutive edges k+1..k+3; position = −3; done at k+3.
- Zero steps: cmd_steps = 0 → done pulse for one cycle, busy stays 0, enc_out and position unchanged, aborted = 0.
- Abort: steps = 10, period = 5, cmd_abort on edge k+15 (step 3 due) → only 2 edges emitted, steps_left = 8, done = 1, aborted = 1, busy = 0.
- Wrap: preload position to 0x7FFFFFFF via 2^31−1 forward steps (or force in bench), one forward step → position = 0x80000000; one reverse step from 0 → 0xFFFFFFFF.
- Reset mid-run: reset high during RUN between edges → enc_out = 00, position = 0, cmd_ready = 1 immediately, no done pulse; new command after release behaves as first test.
